// File: rtl/ip_pkg.sv
// Shared IPv4 constants and the transmit FSM state encoding.
// The IP receiver imports the same protocol constants.
package ip_pkg;

    typedef enum logic [5:0] {
        ST_IDLE    = 6'b000001,
        ST_CSUM    = 6'b000010,
        ST_READY   = 6'b000100,
        ST_HEADER  = 6'b001000,
        ST_PAYLOAD = 6'b010000,
        ST_DONE    = 6'b100000
    } ip_state_t;

    localparam logic [7:0] IP_VER_IHL     = 8'h45;
    localparam logic [7:0] PROTO_ICMP     = 8'h01;
    localparam logic [7:0] PROTO_UDP      = 8'h11;
    localparam int         IP_HDR_LEN     = 20;
    localparam int         IP_MAX_PAYLOAD = 1480;

endpackage

// File: rtl/ip_csum16.sv
// 20-bit ones'-complement accumulator producing a folded, inverted 16-bit checksum.
// Shared by the IP header, UDP and ICMP checksum paths.
module ip_csum16 #(
    parameter bit REG_OUT = 1'b1
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_clr,
    input  logic        i_add,
    input  logic [15:0] i_word,
    input  logic        i_fold,
    output logic [15:0] o_csum
);

    logic [19:0] r_acc;
    logic [15:0] r_csum;
    logic [16:0] w_sum;
    logic [15:0] w_fold;

    // 20 bits hold up to 16 full words, so a single end-around fold is enough.
    assign w_sum  = {1'b0, r_acc[15:0]} + {13'd0, r_acc[19:16]};
    assign w_fold = ~(w_sum[15:0] + {15'd0, w_sum[16]});
    assign o_csum = REG_OUT ? r_csum : w_fold;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_acc  <= '0;
            r_csum <= '0;
        end else begin
            if (i_clr)
                r_acc <= '0;
            else if (i_add)
                r_acc <= r_acc + {4'd0, i_word};
            if (i_fold)
                r_csum <= w_fold;
        end
    end

endmodule

// File: rtl/ip_send.sv
// IPv4 transmit: builds and checksums the 20-byte header, then forwards
// payload bytes from the UDP/ICMP sender to the MAC framer.
module ip_send
    import ip_pkg::*;
#(
    parameter logic [7:0] TTL      = 8'd128,
    parameter logic       DF       = 1'b1,
    parameter int         CSUM_REG = 1
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        send_req,
    input  logic        is_icmp,
    input  logic [10:0] payload_len,
    input  logic [31:0] local_ip,
    input  logic [31:0] to_ip,
    output logic        busy,
    output logic        hdr_ready,
    input  logic        tx_enable,
    output logic [7:0]  data,
    output logic        active,
    input  logic [7:0]  payload_data,
    output logic        done,
    output logic        aborted
);

    ip_state_t   r_state, w_state_nxt;
    logic        r_is_icmp;
    logic [10:0] r_len;
    logic [31:0] r_src, r_dst;
    logic [10:0] r_byte_no;
    logic [3:0]  r_cnt;
    logic [15:0] r_ip_id;
    logic        r_aborted;

    logic        w_accept, w_abort;
    logic [15:0] w_total_len, w_flags, w_csum_word, w_csum;
    logic [7:0]  w_proto, w_hdr_byte;

    assign w_accept    = send_req && (r_state == ST_IDLE) && (payload_len <= 11'(IP_MAX_PAYLOAD));
    assign w_abort     = ((r_state == ST_HEADER) || (r_state == ST_PAYLOAD)) && !tx_enable;
    assign w_total_len = 16'(IP_HDR_LEN) + {5'd0, r_len};
    assign w_flags     = {1'b0, DF, 14'd0};
    assign w_proto     = r_is_icmp ? PROTO_ICMP : PROTO_UDP;

    ip_csum16 #(.REG_OUT(CSUM_REG != 0)) u_csum (
        .i_clk   (clock),
        .i_rst_n (reset_n),
        .i_clr   (w_accept),
        .i_add   ((r_state == ST_CSUM) && (r_cnt <= 4'd8)),
        .i_word  (w_csum_word),
        .i_fold  ((r_state == ST_CSUM) && (r_cnt == 4'd9)),
        .o_csum  (w_csum)
    );

    always_ff @(posedge clock) begin
        if (!reset_n)
            r_state <= ST_IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        busy        = (r_state != ST_IDLE);
        hdr_ready   = (r_state == ST_READY) || (r_state == ST_HEADER) || (r_state == ST_PAYLOAD);
        done        = (r_state == ST_DONE);
        active      = tx_enable && (r_state == ST_PAYLOAD);
        aborted     = r_aborted;
        data        = 8'h00;
        case (r_state)
            ST_IDLE:    if (w_accept) w_state_nxt = ST_CSUM;
            ST_CSUM:    if (r_cnt == 4'd9) w_state_nxt = ST_READY;
            ST_READY: begin
                data = w_hdr_byte;
                if (tx_enable) w_state_nxt = ST_HEADER;
            end
            ST_HEADER: begin
                data = w_hdr_byte;
                if (!tx_enable)
                    w_state_nxt = ST_IDLE;
                else if (r_byte_no == 11'(IP_HDR_LEN))
                    w_state_nxt = (r_len == 11'd0) ? ST_DONE : ST_PAYLOAD;
            end
            ST_PAYLOAD: begin
                data = payload_data;
                if (!tx_enable)
                    w_state_nxt = ST_IDLE;
                else if (r_byte_no == r_len)
                    w_state_nxt = ST_DONE;
            end
            ST_DONE:    w_state_nxt = ST_IDLE;
            default:    w_state_nxt = ST_IDLE;
        endcase
    end

    // Checksum word sequence, one per CSUM cycle.
    always_comb begin
        w_csum_word = 16'h0000;
        case (r_cnt)
            4'd0: w_csum_word = {IP_VER_IHL, 8'h00};
            4'd1: w_csum_word = w_total_len;
            4'd2: w_csum_word = r_ip_id;
            4'd3: w_csum_word = w_flags;
            4'd4: w_csum_word = {TTL, w_proto};
            4'd5: w_csum_word = r_src[31:16];
            4'd6: w_csum_word = r_src[15:0];
            4'd7: w_csum_word = r_dst[31:16];
            4'd8: w_csum_word = r_dst[15:0];
            default: w_csum_word = 16'h0000;
        endcase
    end

    always_comb begin
        w_hdr_byte = 8'h00;
        case (r_byte_no)
            11'd1:  w_hdr_byte = IP_VER_IHL;
            11'd2:  w_hdr_byte = 8'h00;
            11'd3:  w_hdr_byte = w_total_len[15:8];
            11'd4:  w_hdr_byte = w_total_len[7:0];
            11'd5:  w_hdr_byte = r_ip_id[15:8];
            11'd6:  w_hdr_byte = r_ip_id[7:0];
            11'd7:  w_hdr_byte = w_flags[15:8];
            11'd8:  w_hdr_byte = w_flags[7:0];
            11'd9:  w_hdr_byte = TTL;
            11'd10: w_hdr_byte = w_proto;
            11'd11: w_hdr_byte = w_csum[15:8];
            11'd12: w_hdr_byte = w_csum[7:0];
            11'd13: w_hdr_byte = r_src[31:24];
            11'd14: w_hdr_byte = r_src[23:16];
            11'd15: w_hdr_byte = r_src[15:8];
            11'd16: w_hdr_byte = r_src[7:0];
            11'd17: w_hdr_byte = r_dst[31:24];
            11'd18: w_hdr_byte = r_dst[23:16];
            11'd19: w_hdr_byte = r_dst[15:8];
            11'd20: w_hdr_byte = r_dst[7:0];
            default: w_hdr_byte = 8'h00;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_cnt     <= '0;
            r_byte_no <= '0;
            r_ip_id   <= '0;
            r_aborted <= 1'b0;
        end else begin
            r_aborted <= w_abort;
            if (w_abort || (r_state == ST_DONE))
                r_ip_id <= r_ip_id + 16'd1;
            if (w_accept)
                r_cnt <= '0;
            else if (r_state == ST_CSUM)
                r_cnt <= r_cnt + 4'd1;
            // byte_no is 1-based; READY already presents byte 1.
            if (w_accept)
                r_byte_no <= 11'd1;
            else if (tx_enable) begin
                case (r_state)
                    ST_READY:   r_byte_no <= 11'd2;
                    ST_HEADER:  r_byte_no <= (r_byte_no == 11'(IP_HDR_LEN)) ? 11'd1 : r_byte_no + 11'd1;
                    ST_PAYLOAD: r_byte_no <= r_byte_no + 11'd1;
                    default:    r_byte_no <= r_byte_no;
                endcase
            end
        end
    end

    always_ff @(posedge clock) begin
        if (w_accept) begin
            r_is_icmp <= is_icmp;
            r_len     <= payload_len;
            r_src     <= local_ip;
            r_dst     <= to_ip;
        end
    end

endmodule
